// File: rtl/line_follower_pkg.sv
// Command codes shared with the motor controller, the ASCII command set and RX FSM states.
// Also holds the byte-to-command lookup used by the voice receiver.
package line_follower_pkg;

   localparam logic [2:0] CMD_AUTO  = 3'b000;
   localparam logic [2:0] CMD_FWD   = 3'b001;
   localparam logic [2:0] CMD_RIGHT = 3'b010;
   localparam logic [2:0] CMD_LEFT  = 3'b011;
   localparam logic [2:0] CMD_STOP  = 3'b100;
   localparam logic [2:0] CMD_REV   = 3'b101;

   localparam logic [7:0] ASCII_F = 8'h46;
   localparam logic [7:0] ASCII_R = 8'h52;
   localparam logic [7:0] ASCII_L = 8'h4C;
   localparam logic [7:0] ASCII_S = 8'h53;
   localparam logic [7:0] ASCII_B = 8'h42;
   localparam logic [7:0] ASCII_A = 8'h41;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t RX_IDLE  = 2'd0;
   localparam rx_state_t RX_START = 2'd1;
   localparam rx_state_t RX_DATA  = 2'd2;
   localparam rx_state_t RX_STOP  = 2'd3;

   typedef struct packed {
      logic       hit;
      logic [2:0] cmd;
   } cmd_lookup_t;

   function automatic cmd_lookup_t decode_cmd(input logic [7:0] b);
      cmd_lookup_t r;
      r.hit = 1'b1;
      r.cmd = CMD_AUTO;
      case (b)
         ASCII_F: r.cmd = CMD_FWD;
         ASCII_R: r.cmd = CMD_RIGHT;
         ASCII_L: r.cmd = CMD_LEFT;
         ASCII_S: r.cmd = CMD_STOP;
         ASCII_B: r.cmd = CMD_REV;
         ASCII_A: r.cmd = CMD_AUTO;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

   // Only driving commands time out; Stop and Auto are safe to hold forever.
   function automatic logic is_motion(input logic [2:0] c);
      return (c == CMD_FWD) || (c == CMD_RIGHT) || (c == CMD_LEFT) || (c == CMD_REV);
   endfunction

endpackage

// File: rtl/voice_cmd_receiver_if.sv
// Serial line in, command code and status pulses out; slave side is the receiver, master side drives rx_in.
// Plain wires, no flow control: the motor controller always accepts cmd.
interface voice_cmd_receiver_if;
   logic       rx_in;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       unknown_cmd;
   logic       frame_err;

   modport master (output rx_in, input cmd, cmd_valid, unknown_cmd, frame_err);
   modport slave  (input rx_in, output cmd, cmd_valid, unknown_cmd, frame_err);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 2-flop input synchroniser; rx_done_o/rx_ferr_o pulse on the edge after the stop sample.
// No backpressure: each byte is presented for one cycle and must be consumed then.
module uart_rx_8n1
   import line_follower_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] rx_byte_o,
   output logic       rx_done_o,
   output logic       rx_ferr_o
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          sync1_q, sync2_q;
   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!sync2_q) begin
               state_d = RX_START;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         RX_START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (cnt_q == BIT_LAST) begin
               done_d  = sync2_q;
               ferr_d  = !sync2_q;
               state_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_byte_o = shift_q;
   assign rx_done_o = done_q;
   assign rx_ferr_o = ferr_q;

endmodule

// File: rtl/voice_cmd_receiver.sv
// Voice UART bytes -> 3-bit motor command with auto-expiry of motion commands back to line-follow.
// cmd/cmd_valid register one edge after the receiver's done pulse; no backpressure.
module voice_cmd_receiver
   import line_follower_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208,
   parameter int HOLD_CYCLES  = 100_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   voice_cmd_receiver_if.slave  bus
);

   localparam int            HW        = $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   logic [7:0]    rx_byte;
   logic          rx_done, rx_ferr;
   cmd_lookup_t   lookup;
   logic [2:0]    cmd_q, cmd_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          valid_q, valid_d;
   logic          unk_q, unk_d;
   logic          ferr_q, ferr_d;

   uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx_i      (bus.rx_in),
      .rx_byte_o (rx_byte),
      .rx_done_o (rx_done),
      .rx_ferr_o (rx_ferr)
   );

   always_comb begin
      lookup  = decode_cmd(rx_byte);
      cmd_d   = cmd_q;
      hold_d  = hold_q;
      valid_d = 1'b0;
      unk_d   = 1'b0;
      ferr_d  = rx_ferr;
      // A motion command with a drained counter has timed out; the drain edge itself counts as held.
      if (hold_q != '0)        hold_d = hold_q - 1'b1;
      else if (is_motion(cmd_q)) cmd_d = CMD_AUTO;
      if (rx_done) begin
         if (lookup.hit) begin
            cmd_d   = lookup.cmd;
            valid_d = 1'b1;
            hold_d  = is_motion(lookup.cmd) ? HOLD_LOAD : '0;
         end else begin
            unk_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q   <= CMD_AUTO;
         hold_q  <= '0;
         valid_q <= 1'b0;
         unk_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         cmd_q   <= cmd_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         unk_q   <= unk_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.cmd         = cmd_q;
   assign bus.cmd_valid   = valid_q;
   assign bus.unknown_cmd = unk_q;
   assign bus.frame_err   = ferr_q;

endmodule

// File: tb/tb_voice_cmd_receiver.sv
// Scoreboarded bench: directed scenarios then random bytes against a command-table and deadline model.
module tb_voice_cmd_receiver;

   localparam int CPB  = 16;
   localparam int HOLD = 1000;
   localparam int EV_VALID = 0;
   localparam int EV_UNK   = 1;
   localparam int EV_FERR  = 2;

   typedef struct {
      int         kind;
      logic [2:0] cmd;
      int         start;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   voice_cmd_receiver_if bus_if ();

   voice_cmd_receiver #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   exp_t       exp_q[$];
   int         tbl[logic [7:0]];
   logic [2:0] model_cmd = 3'd0;
   int         deadline = -1;
   int         lat = -1;
   int         last_load_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit motion(input logic [2:0] c);
      return (c == 3'd1) || (c == 3'd2) || (c == 3'd3) || (c == 3'd5);
   endfunction

   // Monitor: pops one expected event per DUT pulse and tracks the expected cmd every cycle.
   exp_t e_m;
   int   npulse;
   int   dut_kind;
   always @(negedge clk) begin
      if (rst) begin
         model_cmd = 3'd0;
         deadline  = -1;
         check("reset_cmd", int'(bus_if.cmd), 0);
         check("reset_pulses", int'(bus_if.cmd_valid) + int'(bus_if.unknown_cmd) + int'(bus_if.frame_err), 0);
      end else begin
         if (motion(model_cmd) && cyc == deadline) begin
            model_cmd = 3'd0;
            deadline  = -1;
         end
         npulse = int'(bus_if.cmd_valid) + int'(bus_if.unknown_cmd) + int'(bus_if.frame_err);
         if (npulse > 1) check("pulse_exclusive", npulse, 1);
         if (npulse != 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", npulse, 0);
            end else begin
               e_m = exp_q.pop_front();
               dut_kind = bus_if.cmd_valid ? EV_VALID : (bus_if.unknown_cmd ? EV_UNK : EV_FERR);
               check("pulse_kind", dut_kind, e_m.kind);
               if (e_m.kind == EV_VALID) begin
                  check("cmd_on_valid", int'(bus_if.cmd), int'(e_m.cmd));
                  model_cmd = e_m.cmd;
                  deadline  = motion(e_m.cmd) ? cyc + HOLD : -1;
                  if (lat < 0) lat = cyc - e_m.start;
                  else         check("byte_latency", cyc - e_m.start, lat);
                  last_load_cyc = cyc;
               end
            end
         end
         check("cmd_track", int'(bus_if.cmd), int'(model_cmd));
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      exp_t e;
      e.cmd = 3'd0;
      if (!stop_ok) e.kind = EV_FERR;
      else if (tbl.exists(b)) begin
         e.kind = EV_VALID;
         e.cmd  = 3'(tbl[b]);
      end else e.kind = EV_UNK;
      @(negedge clk);
      e.start = cyc;
      exp_q.push_back(e);
      bus_if.rx_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus_if.rx_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      bus_if.rx_in = stop_ok;
      repeat (CPB) @(negedge clk);
      bus_if.rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int          f_load;
   int          target;
   logic [7:0]  pool[6];
   logic [7:0]  rb;

   initial begin
      tbl[8'h46] = 1; tbl[8'h52] = 2; tbl[8'h4C] = 3;
      tbl[8'h53] = 4; tbl[8'h42] = 5; tbl[8'h41] = 0;
      pool = '{8'h46, 8'h52, 8'h4C, 8'h53, 8'h42, 8'h41};
      bus_if.rx_in = 1'b1;
      rst = 1'b1;
      idle(5);
      rst = 1'b0;
      idle(5);

      // Reset in the middle of a frame; the partial byte must vanish.
      bus_if.rx_in = 1'b0;
      idle(40);
      rst = 1'b1;
      bus_if.rx_in = 1'b1;
      idle(4);
      rst = 1'b0;
      idle(3 * CPB);
      send_byte(8'h46, 1'b1);
      idle(10);
      check("fwd_after_reset", int'(bus_if.cmd), 1);

      // Expiry to Auto, then Stop never expires.
      idle(HOLD + 50);
      check("fwd_expired", int'(bus_if.cmd), 0);
      send_byte(8'h53, 1'b1);
      idle(5200);
      check("stop_holds", int'(bus_if.cmd), 4);

      // Framing error leaves cmd alone; receiver recovers.
      send_byte(8'h52, 1'b0);
      check("cmd_after_ferr", int'(bus_if.cmd), 4);
      send_byte(8'h4C, 1'b1);
      idle(10);
      check("left_after_ferr", int'(bus_if.cmd), 3);

      // Unknown byte during a pending timeout.
      send_byte(8'h5A, 1'b1);
      check("cmd_after_unknown", int'(bus_if.cmd), 3);
      idle(HOLD);
      check("left_expired", int'(bus_if.cmd), 0);

      // Short glitch is ignored.
      bus_if.rx_in = 1'b0;
      idle(4);
      bus_if.rx_in = 1'b1;
      idle(3 * CPB);
      send_byte(8'h42, 1'b1);
      idle(10);
      check("rev_after_glitch", int'(bus_if.cmd), 5);
      idle(HOLD + 50);

      // A new byte landing on the expiry cycle wins and reloads the timer.
      send_byte(8'h46, 1'b1);
      idle(10);
      f_load = last_load_cyc;
      target = f_load + HOLD - lat;
      while (cyc < target - 1) @(negedge clk);
      send_byte(8'h52, 1'b1);
      idle(10);
      check("collision_load_cycle", last_load_cyc, f_load + HOLD);
      check("collision_cmd", int'(bus_if.cmd), 2);
      idle(HOLD - 100);
      check("collision_reloaded", int'(bus_if.cmd), 2);
      idle(200);
      check("collision_expired", int'(bus_if.cmd), 0);

      // Random traffic.
      for (int n = 0; n < 25; n++) begin
         rb = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : 8'($urandom);
         send_byte(rb, $urandom_range(0, 9) != 0);
         idle(($urandom_range(0, 4) == 0) ? HOLD : $urandom_range(0, 300));
      end

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
